// File: rtl/riscv_mini_ihp.sv
// riscv_mini_ihp: Tiny-Tapeout RISC-V mini core.
// Byte-loadable 16-word instruction RAM, four 8-bit registers (x0..x3),
// single-cycle execution of a small RV32I subset. x3 drives uo_out; the
// halted flag and the PC drive uio_out.
module riscv_mini_ihp (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int IMEM_WORDS = 16;
    localparam int XLEN       = 8;
    localparam int NREGS      = 4;

    localparam logic [6:0]  OPC_OPIMM   = 7'h13;
    localparam logic [6:0]  OPC_OP      = 7'h33;
    localparam logic [6:0]  OPC_BRANCH  = 7'h63;
    localparam logic [6:0]  OPC_JAL     = 7'h6F;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    // ------------------------------------------------------------------
    // Pad-ring inputs
    // ------------------------------------------------------------------
    logic       mode_load;
    logic       byte_valid;
    logic [5:0] unused_uio;

    assign mode_load  = uio_in[0];
    assign byte_valid = uio_in[1];
    assign unused_uio = uio_in[7:2];

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [3:0]      pc_q, pc_d;
    logic            halted_q, halted_d;
    logic [5:0]      ptr_q, ptr_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Instruction RAM stored as byte lanes so the loader can write one byte
    // per cycle; it is deliberately left out of reset.
    logic [3:0][7:0] imem_q [IMEM_WORDS];
    logic            imem_we;

    // ------------------------------------------------------------------
    // Fetch and field extraction
    // ------------------------------------------------------------------
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            sub_sel;
    logic [1:0]      rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0] imm_i;
    logic [3:0]      br_off;
    logic [3:0]      jal_off;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign instr   = imem_q[pc_q];
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign sub_sel = instr[30];
    // Only the low two bits of each register field are decoded, so x4..x31
    // alias onto x0..x3.
    assign rd_idx  = instr[8:7];
    assign rs1_idx = instr[16:15];
    assign rs2_idx = instr[21:20];
    // I-type immediate truncated to the 8-bit datapath.
    assign imm_i   = instr[27:20];
    // Word offsets: byte-offset bits [5:2] of the B/J immediates. Anything
    // above bit 5 vanishes in the mod-16 PC add and bits [1:0] are dropped.
    assign br_off  = {instr[25], instr[11:9]};
    assign jal_off = instr[25:22];

    // regs_q[0] is held at zero, so x0 reads need no special case.
    assign rs1_val = regs_q[rs1_idx];
    assign rs2_val = regs_q[rs2_idx];

    // ------------------------------------------------------------------
    // Execute: result, writeback enable, next PC and halt for the current
    // instruction, assuming the core is running.
    // ------------------------------------------------------------------
    logic [3:0]      ex_pc;
    logic            ex_halt;
    logic            ex_we;
    logic [XLEN-1:0] ex_wdata;
    logic            br_taken;

    // Decode and evaluate one instruction; unknown encodings fall through as NOPs.
    always_comb begin
        ex_pc    = pc_q + 4'd1;
        ex_halt  = 1'b0;
        ex_we    = 1'b0;
        ex_wdata = '0;
        br_taken = 1'b0;
        case (opcode)
            OPC_OPIMM: begin
                case (funct3)
                    3'd0: begin ex_we = 1'b1; ex_wdata = rs1_val + imm_i; end
                    3'd4: begin ex_we = 1'b1; ex_wdata = rs1_val ^ imm_i; end
                    3'd6: begin ex_we = 1'b1; ex_wdata = rs1_val | imm_i; end
                    3'd7: begin ex_we = 1'b1; ex_wdata = rs1_val & imm_i; end
                    default: ;
                endcase
            end
            OPC_OP: begin
                case (funct3)
                    3'd0: begin
                        ex_we    = 1'b1;
                        ex_wdata = sub_sel ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
                    end
                    3'd4: begin ex_we = 1'b1; ex_wdata = rs1_val ^ rs2_val; end
                    3'd6: begin ex_we = 1'b1; ex_wdata = rs1_val | rs2_val; end
                    3'd7: begin ex_we = 1'b1; ex_wdata = rs1_val & rs2_val; end
                    default: ;
                endcase
            end
            OPC_BRANCH: begin
                if (funct3 == 3'd0)      br_taken = (rs1_val == rs2_val);
                else if (funct3 == 3'd1) br_taken = (rs1_val != rs2_val);
                if (br_taken) ex_pc = pc_q + br_off;
            end
            OPC_JAL: begin
                // Link value is the byte address of the next instruction.
                ex_we    = 1'b1;
                ex_wdata = {2'b00, pc_q, 2'b00} + 8'd4;
                ex_pc    = pc_q + jal_off;
            end
            default: begin
                if (instr == INSN_EBREAK) begin
                    ex_halt = 1'b1;
                    ex_pc   = pc_q;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next state: ena gates everything, LOAD overrides RUN, halt freezes RUN.
    // ------------------------------------------------------------------
    // Select between hold, load and execute for all architectural state.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        ptr_d    = ptr_q;
        regs_d   = regs_q;
        imem_we  = 1'b0;
        if (ena) begin
            if (mode_load) begin
                pc_d     = 4'd0;
                halted_d = 1'b0;
                for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
                if (byte_valid) begin
                    imem_we = 1'b1;
                    ptr_d   = ptr_q + 6'd1;
                end
            end else if (!halted_q) begin
                pc_d     = ex_pc;
                halted_d = ex_halt;
                if (ex_we && (rd_idx != 2'd0)) regs_d[rd_idx] = ex_wdata;
            end
        end
    end

    // Control and register-file state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= 4'd0;
            halted_q <= 1'b0;
            ptr_q    <= 6'd0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            ptr_q    <= ptr_d;
            regs_q   <= regs_d;
        end
    end

    // Byte write into the instruction RAM, little-endian within each word.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[ptr_q[5:2]][ptr_q[1:0]] <= ui_in;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign uo_out  = regs_q[3];
    assign uio_out = {halted_q, pc_q, 3'b000};
    assign uio_oe  = 8'hF8;

endmodule

// File: tb/tb_riscv_mini_ihp.sv
// Directed bench for riscv_mini_ihp: a table of small programs with expected
// final x3/PC, plus hand-written sequences for reset, load, ena and looping.
module tb_riscv_mini_ihp;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h01;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] EBRK = 32'h0010_0073;

    riscv_mini_ihp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           nm;
        logic [7:0]      x3;
        logic [3:0]      pc;
        logic [7:0][31:0] w;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] prog [16];

    function automatic vec_t mk(input string nm, input logic [7:0] x3, input logic [3:0] pc,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] w4, input logic [31:0] w5,
                                input logic [31:0] w6);
        vec_t v;
        v.nm = nm; v.x3 = x3; v.pc = pc;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.w[4] = w4; v.w[5] = w5; v.w[6] = w6; v.w[7] = EBRK;
        return v;
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic [7:0] x3, input logic h, input logic [3:0] pc);
        chk8({nm, " x3"}, uo_out, x3);
        chk8({nm, " halt/pc"}, uio_out, {h, pc, 3'b000});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Stream all 64 bytes of prog[] (little-endian), leaving mode=1, valid=0.
    task automatic load_prog();
        uio_in = 8'b0000_0011;
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) begin
                ui_in = prog[w][8*b +: 8];
                tick();
            end
        end
        uio_in = 8'b0000_0001;
        tick();
    endtask

    task automatic set_prog(input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < 16; i++) prog[i] = EBRK;
        prog[0] = w0;
        prog[1] = w1;
    endtask

    initial begin
        // name, x3, pc, program words (EBREAK-terminated)
        vecs[0]  = mk("addi",      8'h05, 4'd1, 32'h00500193, EBRK, EBRK, EBRK, EBRK, EBRK, EBRK);
        vecs[1]  = mk("sub",       8'h04, 4'd3, 32'h00700093, 32'h00300113, 32'h402081B3, EBRK, EBRK, EBRK, EBRK);
        vecs[2]  = mk("and",       8'hC0, 4'd3, 32'h0F000093, 32'h0CC00113, 32'h0020F1B3, EBRK, EBRK, EBRK, EBRK);
        vecs[3]  = mk("or",        8'hFC, 4'd3, 32'h0F000093, 32'h0CC00113, 32'h0020E1B3, EBRK, EBRK, EBRK, EBRK);
        vecs[4]  = mk("xor",       8'h3C, 4'd3, 32'h0F000093, 32'h0CC00113, 32'h0020C1B3, EBRK, EBRK, EBRK, EBRK);
        vecs[5]  = mk("add_wrap",  8'h2C, 4'd3, 32'h0C800093, 32'h06400113, 32'h002081B3, EBRK, EBRK, EBRK, EBRK);
        vecs[6]  = mk("sub_neg",   8'hFE, 4'd3, 32'h00300093, 32'h00500113, 32'h402081B3, EBRK, EBRK, EBRK, EBRK);
        vecs[7]  = mk("imm_trunc", 8'hAB, 4'd2, 32'hFFF00193, 32'h1AB00193, EBRK, EBRK, EBRK, EBRK, EBRK);
        vecs[8]  = mk("logic_imm", 8'hA4, 4'd4, 32'h0AB00193, 32'h00F1F193, 32'h0501E193, 32'h0FF1C193, EBRK, EBRK, EBRK);
        vecs[9]  = mk("alias",     8'h09, 4'd3, 32'h00900393, 32'h00500213, 32'h004381B3, EBRK, EBRK, EBRK, EBRK);
        vecs[10] = mk("nops",      8'h06, 4'd5, 32'h00600193, 32'h00000000, 32'h00702193, 32'h00000073, 32'h123451B7, EBRK, EBRK);
        vecs[11] = mk("jal_link",  8'h0C, 4'd4, 32'h00700093, 32'h00300113, 32'h008001EF, 32'h00100193, EBRK, EBRK, EBRK);
        vecs[12] = mk("beq_bne",   8'h01, 4'd6, 32'h00200093, 32'h00200113, 32'h00208463, 32'h00900193, 32'h00209463, 32'h00118193, EBRK);

        // Reset
        ena = 1'b1;
        #2 rst_n = 1'b0;
        ticks(2);
        chk8("reset uo_out", uo_out, 8'h00);
        chk8("reset uio_out", uio_out, 8'h00);
        chk8("reset uio_oe", uio_oe, 8'hF8);
        rst_n = 1'b1;
        tick();

        // ADDI x3,x0,5 then EBREAK, stepped cycle by cycle
        set_prog(32'h00500193, EBRK);
        load_prog();
        chk_state("loaded", 8'h00, 1'b0, 4'd0);
        uio_in = 8'h00;
        tick();
        chk_state("step1", 8'h05, 1'b0, 4'd1);
        tick();
        chk_state("step2", 8'h05, 1'b1, 4'd1);
        ticks(3);
        chk_state("halt_hold", 8'h05, 1'b1, 4'd1);

        // ena=0 in LOAD with valid bytes: nothing written, nothing cleared
        uio_in = 8'b0000_0011;
        ui_in  = 8'h13;
        ena    = 1'b0;
        ticks(3);
        chk_state("ena0_load", 8'h05, 1'b1, 4'd1);
        ena    = 1'b1;
        uio_in = 8'b0000_0001;
        tick();
        chk_state("mode1_clears", 8'h00, 1'b0, 4'd0);
        uio_in = 8'h00;
        ticks(4);
        chk_state("after_ena0", 8'h05, 1'b1, 4'd1);

        // 65th byte lands on byte 0: ADDI x3 becomes ADDI x2
        uio_in = 8'b0000_0011;
        ui_in  = 8'h13;
        tick();
        uio_in = 8'h00;
        ticks(4);
        chk_state("ptr_wrap", 8'h00, 1'b1, 4'd1);

        // Reset clears halted/pc and the load pointer
        uio_in = 8'b0000_0001;
        rst_n  = 1'b0;
        tick();
        chk_state("reset2", 8'h00, 1'b0, 4'd0);
        rst_n = 1'b1;
        tick();

        // Program table
        for (int v = 0; v < 13; v++) begin
            for (int i = 0; i < 16; i++) prog[i] = (i < 8) ? vecs[v].w[i] : EBRK;
            load_prog();
            uio_in = 8'h00;
            ticks(20);
            chk_state(vecs[v].nm, vecs[v].x3, 1'b1, vecs[v].pc);
        end

        // Counting loop: ADDI x3,x3,1 / JAL x0,-4
        set_prog(32'h00118193, 32'hFFDFF06F);
        load_prog();
        uio_in = 8'h00;
        tick();
        chk_state("loop1", 8'h01, 1'b0, 4'd1);
        tick();
        chk_state("loop2", 8'h01, 1'b0, 4'd0);
        ticks(508);
        chk_state("loop510", 8'hFF, 1'b0, 4'd0);
        tick();
        chk_state("loop_wrap", 8'h00, 1'b0, 4'd1);

        // ena=0 holds state regardless of mode
        ena = 1'b0;
        ticks(5);
        chk_state("ena0_run", 8'h00, 1'b0, 4'd1);
        uio_in = 8'b0000_0001;
        ticks(3);
        chk_state("ena0_mode1", 8'h00, 1'b0, 4'd1);
        uio_in = 8'h00;
        ena    = 1'b1;
        tick();
        chk_state("resume_jal", 8'h00, 1'b0, 4'd0);
        tick();
        chk_state("resume_addi", 8'h01, 1'b0, 4'd1);

        // mode=1 mid-run wins over execution
        uio_in = 8'b0000_0001;
        tick();
        chk_state("mode1_midrun", 8'h00, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
